keccak_msg_arbiter: RTL and testbench



---
 rtl/keccak_msg_arbiter.sv | 161 ++++++++++++++++
 tb/tb_keccak_msg_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_msg_arbiter.sv
// Round-robin front-end sharing one keccak core between two requesters.
// Ports: clk/reset; s0_*/s1_* word streams (valid/data/last/bytes/ready);
// dig_* digest bus (valid/id/data/ready); busy; core_* drive and return.
module keccak_msg_arbiter #(
  parameter int CLR_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_valid,
  input  logic [63:0]  s0_data,
  input  logic         s0_last,
  input  logic [3:0]   s0_bytes,
  output logic         s0_ready,
  input  logic         s1_valid,
  input  logic [63:0]  s1_data,
  input  logic         s1_last,
  input  logic [3:0]   s1_bytes,
  output logic         s1_ready,
  output logic         dig_valid,
  output logic         dig_id,
  output logic [511:0] dig_data,
  input  logic         dig_ready,
  output logic         busy,
  output logic         core_reset,
  output logic [63:0]  core_in,
  output logic         core_in_ready,
  output logic         core_is_last,
  output logic [2:0]   core_byte_num,
  input  logic         core_buffer_full,
  input  logic [511:0] core_out,
  input  logic         core_out_ready
);

  typedef enum logic [2:0] {
    IDLE, CLR, FEED, PAD, WAIT, HOLD
  } state_e;

  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

  state_e       state_q, state_d;
  logic         gnt_q, gnt_d;
  logic         ptr_q, ptr_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         dig_valid_q, dig_valid_d;
  logic         dig_id_q, dig_id_d;
  logic [511:0] dig_data_q, dig_data_d;

  logic         sel_valid;
  logic [63:0]  sel_data;
  logic         sel_last;
  logic [3:0]   sel_bytes;
  logic         sel_full;
  logic         xfer;

  assign sel_valid = gnt_q ? s1_valid : s0_valid;
  assign sel_data  = gnt_q ? s1_data  : s0_data;
  assign sel_last  = gnt_q ? s1_last  : s0_last;
  assign sel_bytes = gnt_q ? s1_bytes : s0_bytes;

  // A zero byte count cannot describe a last word, so it means a full word.
  assign sel_full  = sel_bytes[3] | (sel_bytes == 4'd0);
  assign xfer      = sel_valid & ~core_buffer_full;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    dig_valid_d   = dig_valid_q;
    dig_id_d      = dig_id_q;
    dig_data_d    = dig_data_q;
    s0_ready      = 1'b0;
    s1_ready      = 1'b0;
    core_in       = '0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = '0;
    unique case (state_q)
      IDLE: begin
        if (s0_valid | s1_valid) begin
          gnt_d   = (s0_valid & s1_valid) ? ptr_q : s1_valid;
          ptr_d   = ~gnt_d;
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CLR_LAST) state_d = FEED;
      end
      FEED: begin
        core_in       = sel_data;
        core_in_ready = sel_valid;
        s0_ready      = ~gnt_q & ~core_buffer_full;
        s1_ready      = gnt_q & ~core_buffer_full;
        if (sel_last & ~sel_full) begin
          core_is_last  = 1'b1;
          core_byte_num = sel_bytes[2:0];
        end
        // A full last word still needs an empty terminator word.
        if (xfer & sel_last) state_d = sel_full ? PAD : WAIT;
      end
      PAD: begin
        core_in_ready = 1'b1;
        core_is_last  = 1'b1;
        if (~core_buffer_full) state_d = WAIT;
      end
      WAIT: begin
        if (core_out_ready) begin
          dig_data_d  = core_out;
          dig_id_d    = gnt_q;
          dig_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (dig_valid_q & dig_ready) begin
          dig_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing may be accepted while the block is held in reset.
    if (reset) begin
      s0_ready      = 1'b0;
      s1_ready      = 1'b0;
      core_in       = '0;
      core_in_ready = 1'b0;
      core_is_last  = 1'b0;
      core_byte_num = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      dig_valid_q <= 1'b0;
      dig_id_q    <= 1'b0;
      dig_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      dig_valid_q <= dig_valid_d;
      dig_id_q    <= dig_id_d;
      dig_data_q  <= dig_data_d;
    end
  end

  assign busy       = ~reset & (state_q != IDLE);
  assign dig_valid  = ~reset & dig_valid_q;
  assign dig_id     = ~reset & dig_id_q;
  assign dig_data   = reset ? '0 : dig_data_q;
  assign core_reset = reset | (state_q == CLR);

endmodule

// File: tb/tb_keccak_msg_arbiter.sv
// Bench for keccak_msg_arbiter: random requesters, core stand-in,
// digest consumer and a message-level reference of the padded stream.
module tb_keccak_msg_arbiter;

  localparam int CLR = 2;
  localparam logic [511:0] H0 = {8{64'hA5A5_0123_4567_89AB}};

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic [3:0]  b;
  } word_t;

  typedef struct {
    logic         id;
    logic [511:0] dig;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic s0_valid, s1_valid;
  logic [63:0] s0_data, s1_data;
  logic s0_last, s1_last;
  logic [3:0] s0_bytes, s1_bytes;
  logic s0_ready, s1_ready;
  logic dig_valid, dig_id, dig_ready;
  logic [511:0] dig_data;
  logic busy, core_reset;
  logic [63:0] core_in;
  logic core_in_ready, core_is_last;
  logic [2:0] core_byte_num;
  logic core_buffer_full;
  logic [511:0] core_out;
  logic core_out_ready;

  keccak_msg_arbiter #(.CLR_CYCLES(CLR)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last),
    .s0_bytes(s0_bytes), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last),
    .s1_bytes(s1_bytes), .s1_ready(s1_ready),
    .dig_valid(dig_valid), .dig_id(dig_id), .dig_data(dig_data),
    .dig_ready(dig_ready), .busy(busy), .core_reset(core_reset),
    .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out),
    .core_out_ready(core_out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  word_t wq0[$];
  word_t wq1[$];
  exp_t  exp_q[$];
  logic [63:0] stage[$];
  int acc[2];
  int pres_cyc[2];
  int lat[2];
  bit first[2];
  int gap_pct = 0;
  bit full_rand = 1'b0;
  bit force_full = 1'b0;
  int dig_mode = 2;
  int beats = 0;
  logic [63:0] lb_w = '0;
  logic lb_l = 1'b0;
  logic [2:0] lb_n = '0;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mix(input logic [511:0] h,
    input logic [63:0] w, input logic l, input logic [2:0] n);
    logic [511:0] r;
    logic [63:0] m;
    m = w * 64'h9E37_79B9_7F4A_7C15;
    r = {h[444:0], h[511:445]};
    r[63:0] = r[63:0] ^ w;
    r[67:64] = r[67:64] ^ {l, n};
    r[511:448] = r[511:448] ^ m;
    return r;
  endfunction

  // Digest of the stream the core should see for the staged message.
  function automatic logic [511:0] ref_digest(input logic [3:0] lb);
    logic [511:0] h;
    int n;
    h = H0;
    n = stage.size();
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) h = mix(h, stage[i], 1'b0, 3'd0);
      else if (lb >= 4'd1 && lb <= 4'd7) h = mix(h, stage[i], 1'b1, lb[2:0]);
      else begin
        h = mix(h, stage[i], 1'b0, 3'd0);
        h = mix(h, 64'd0, 1'b1, 3'd0);
      end
    end
    return h;
  endfunction

  task automatic gen_msg(input int n);
    stage.delete();
    repeat (n) stage.push_back({$urandom(), $urandom()});
  endtask

  task automatic post_msg(input logic id, input logic [3:0] lb);
    int n;
    exp_t e;
    n = stage.size();
    for (int i = 0; i < n; i++) begin
      word_t w;
      w.d = stage[i];
      w.l = (i == n - 1);
      w.b = (i == n - 1) ? lb : 4'd8;
      if (id) wq1.push_back(w);
      else wq0.push_back(w);
    end
    e.id = id;
    e.dig = ref_digest(lb);
    exp_q.push_back(e);
    stage.delete();
  endtask

  task automatic pick(input int id, output logic v, output word_t w);
    int sz;
    sz = id ? wq1.size() : wq0.size();
    v = 1'b0;
    w.d = {$urandom(), $urandom()};
    w.l = 1'($urandom());
    w.b = 4'($urandom());
    if (sz > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
      v = 1'b1;
      w = id ? wq1[0] : wq0[0];
      if (first[id] && pres_cyc[id] < 0) pres_cyc[id] = cyc;
    end
  endtask

  task automatic took(input int id, input word_t w);
    if (id) void'(wq1.pop_front());
    else void'(wq0.pop_front());
    acc[id]++;
    if (first[id]) begin
      lat[id] = cyc - pres_cyc[id];
      pres_cyc[id] = -1;
      first[id] = 1'b0;
    end
    if (w.l) first[id] = 1'b1;
  endtask

  initial begin
    logic v;
    word_t w;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0; s0_bytes = '0;
    forever begin
      @(negedge clk);
      pick(0, v, w);
      s0_valid = v; s0_data = w.d; s0_last = w.l; s0_bytes = w.b;
      #1;
      if (v && s0_ready) took(0, w);
    end
  end

  initial begin
    logic v;
    word_t w;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; s1_bytes = '0;
    forever begin
      @(negedge clk);
      pick(1, v, w);
      s1_valid = v; s1_data = w.d; s1_last = w.l; s1_bytes = w.b;
      #1;
      if (v && s1_ready) took(1, w);
    end
  end

  initial begin
    core_buffer_full = 1'b0;
    forever begin
      @(negedge clk);
      core_buffer_full = force_full |
        (full_rand & ($urandom_range(0, 3) == 0));
    end
  end

  initial begin
    exp_t e;
    logic [1:0] own;
    dig_ready = 1'b0;
    forever begin
      @(negedge clk);
      dig_ready = (dig_mode == 2) ||
        (dig_mode == 0 && $urandom_range(0, 1) == 1);
      #1;
      if (s0_ready | s1_ready) begin
        own = 2'b00;
        if (exp_q.size() > 0) own = exp_q[0].id ? 2'b10 : 2'b01;
        chk("owner", {s1_ready, s0_ready}, own);
      end
      if (dig_valid && dig_ready) begin
        if (exp_q.size() == 0) chk("spurious_dig", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("dig_id", dig_id, e.id);
          chk("dig_data", dig_data, e.dig);
        end
      end
    end
  end

  // Core stand-in: folds every accepted beat, answers a few cycles after
  // the last one and keeps the answer up until its next reset.
  initial begin
    logic [511:0] h, out_n;
    logic rdy_n;
    int dly, run;
    bit rsn;
    core_out_ready = 1'b0; core_out = '0;
    h = H0; out_n = '0; rdy_n = 1'b0; dly = -1; run = 0; rsn = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (core_reset) begin
        run++;
        if (reset) rsn = 1'b1;
        h = H0; dly = -1; rdy_n = 1'b0; beats = 0;
      end else begin
        if (run > 0) begin
          if (!rsn) chk("clr_len", run, CLR);
          run = 0; rsn = 1'b0;
        end
        if (core_in_ready && !core_buffer_full) begin
          h = mix(h, core_in, core_is_last, core_byte_num);
          beats++;
          lb_w = core_in; lb_l = core_is_last; lb_n = core_byte_num;
          if (core_is_last && core_byte_num == 3'd0)
            chk("pad_word", core_in, 0);
          if (core_is_last) dly = $urandom_range(0, 4);
        end else if (dly > 0) dly--;
        else if (dly == 0) begin
          rdy_n = 1'b1; out_n = h; dly = -1;
        end
      end
      @(posedge clk);
      #1;
      core_out_ready = rdy_n;
      core_out = rdy_n ? out_n : {16{$urandom()}};
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && wq0.size() == 0 && wq1.size() == 0
             && !busy) && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 2000) begin
      chk("idle_timeout", 1, 0);
      exp_q.delete(); wq0.delete(); wq1.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [511:0] cap;
    int base;
    reset = 1'b1;
    first[0] = 1'b1; first[1] = 1'b1;
    pres_cyc[0] = -1; pres_cyc[1] = -1;
    acc[0] = 0; acc[1] = 0; lat[0] = 0; lat[1] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    chk("rst_busy", busy, 0);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ready", {s1_ready, s0_ready}, 0);
    chk("rst_in_ready", core_in_ready, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk); #3;
    chk("post_rst_core_reset", core_reset, 0);
    chk("post_rst_busy", busy, 0);

    // Short "abc" message from requester 0.
    @(posedge clk); #2;
    stage.push_back(64'h6162_6300_0000_0000);
    post_msg(1'b0, 4'd3);
    wait_idle();
    chk("abc_beats", beats, 1);
    chk("abc_is_last", lb_l, 1);
    chk("abc_byte_num", lb_n, 3);
    chk("abc_latency", lat[0], CLR + 1);

    // Message ending on an 8-byte boundary from requester 1.
    @(posedge clk); #2;
    gen_msg(2);
    post_msg(1'b1, 4'd8);
    wait_idle();
    chk("b8_beats", beats, 3);
    chk("b8_pad_data", lb_w, 0);
    chk("b8_pad_last", lb_l, 1);
    chk("b8_pad_num", lb_n, 0);

    // Contention right after reset, twice.
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    full_rand = 1'b1; dig_mode = 0;
    repeat (2) begin
      @(posedge clk); #2;
      gen_msg(3); post_msg(1'b0, 4'($urandom_range(1, 8)));
      gen_msg(2); post_msg(1'b1, 4'($urandom_range(1, 8)));
      wait_idle();
    end

    // Core backpressure in the middle of a message.
    gap_pct = 20;
    @(posedge clk); #2;
    base = acc[1];
    gen_msg(6); post_msg(1'b1, 4'd5);
    for (int k = 0; k < 500 && acc[1] < base + 2; k++) begin
      @(posedge clk); #2;
    end
    force_full = 1'b1;
    repeat (20) begin
      @(negedge clk); #3;
      chk("bp_ready", {s1_ready, s0_ready}, 0);
    end
    @(posedge clk); #2;
    force_full = 1'b0;
    wait_idle();

    // Digest consumer stalls while another requester waits.
    gap_pct = 0; dig_mode = 1;
    @(posedge clk); #2;
    gen_msg(2); post_msg(1'b0, 4'd6);
    for (int k = 0; k < 500 && !dig_valid; k++) begin
      @(negedge clk); #3;
    end
    cap = dig_data;
    @(posedge clk); #2;
    gen_msg(1); post_msg(1'b1, 4'd2);
    repeat (50) begin
      @(negedge clk); #3;
      chk("stall_valid", dig_valid, 1);
      chk("stall_data", dig_data, cap);
      chk("stall_no_clr", core_reset, 0);
      chk("stall_s1_ready", s1_ready, 0);
    end
    @(posedge clk); #2;
    dig_mode = 2;
    @(negedge clk); #3;
    @(negedge clk); #3;
    chk("regrant_idle", {busy, core_reset}, 0);
    @(negedge clk); #3;
    chk("regrant_clr", core_reset, 1);
    wait_idle();
    dig_mode = 0;

    // Reset after three words of a longer message.
    full_rand = 1'b0;
    @(posedge clk); #2;
    base = acc[0];
    gen_msg(7); post_msg(1'b0, 4'd4);
    for (int k = 0; k < 500 && acc[0] < base + 3; k++) begin
      @(posedge clk); #2;
    end
    reset = 1'b1;
    wq0.delete(); exp_q.delete();
    first[0] = 1'b1; pres_cyc[0] = -1;
    @(negedge clk); #3;
    chk("midrst_busy", busy, 0);
    chk("midrst_dig_valid", dig_valid, 0);
    chk("midrst_core_reset", core_reset, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    full_rand = 1'b1; gap_pct = 25;
    gen_msg(3); post_msg(1'b0, 4'd7);
    wait_idle();

    // Random single-requester messages.
    repeat (8) begin
      @(posedge clk); #2;
      gen_msg($urandom_range(1, 5));
      post_msg(1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)));
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
